// File: rtl/mips_ex_pkg.sv
// mips_ex_pkg: shared constants for the MIPS32 execute stage
package mips_ex_pkg;
  localparam int XLEN   = 32;
  localparam int ALUC_W = 21;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_SLT  = 6;
  localparam int ALU_SLL  = 7;
  localparam int ALU_SRL  = 8;
  localparam int ALU_SRA  = 9;
  localparam int ALU_LUI  = 10;
  localparam int ALU_MULT = 11;
  localparam int ALU_DIV  = 12;
  localparam int ALU_MFHI = 13;
  localparam int ALU_MFLO = 14;
  localparam int ALU_MTHI = 15;
  localparam int ALU_MTLO = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_t;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier and restoring divider with sign correction
// start/is_div/sign/a/b: request and operands (start in DONE acknowledges the result)
// busy: computing; done: hi/lo valid, waiting for acknowledge
module muldiv_unit
  import mips_ex_pkg::*;
#(
  parameter int MUL_LAT   = 4,
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_div,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  // multiplier bits consumed per cycle so MUL_LAT steps cover all 32
  localparam int K = (XLEN + MUL_LAT - 1) / MUL_LAT;
  md_state_t state;
  logic [5:0] cnt;
  logic div_r, neg_q, neg_r;
  logic [31:0] q, r, d, ma, mb;
  logic [63:0] acc, mcand, prod;
  logic [32:0] t;
  assign ma = (sign & a[31]) ? -a : a;
  assign mb = (sign & b[31]) ? -b : b;
  // remainder is always below the divisor, so t[32] is a clean borrow flag
  assign t = {r, q[31]} - {1'b0, d};
  assign prod = neg_q ? -acc : acc;
  assign lo = div_r ? (neg_q ? -q : q) : prod[31:0];
  assign hi = div_r ? (neg_r ? -r : r) : prod[63:32];
  assign busy = state == BUSY;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      acc   <= '0;
      mcand <= '0;
    end else case (state)
      IDLE: if (start) begin
        state <= BUSY;
        cnt   <= is_div ? 6'(DIV_ITERS) : 6'(MUL_LAT);
        div_r <= is_div;
        neg_q <= sign & (a[31] ^ b[31]);
        neg_r <= sign & a[31];
        q     <= ma;
        d     <= mb;
        r     <= '0;
        acc   <= '0;
        mcand <= {32'd0, mb};
      end
      BUSY: begin
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) state <= DONE;
        if (div_r) begin
          r <= t[32] ? {r[30:0], q[31]} : t[31:0];
          q <= {q[30:0], ~t[32]};
        end else begin
          acc   <= acc + mcand * 64'(q[K-1:0]);
          q     <= q >> K;
          mcand <= mcand << K;
        end
      end
      DONE: if (start) state <= IDLE;
      default: state <= IDLE;
    endcase
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS32 execute stage with HI/LO, mult/div unit and EX/MEM register
// EX_*: decoded instruction bundle; MEM_stall: downstream hold
// EX_stall: combinational hold to ID/EX; MEM_*: registered results and controls
module ex_stage
  import mips_ex_pkg::*;
#(
  parameter int MUL_LAT   = 4,
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_stall,
  input  logic [4:0]  EX_reg_dst,
  input  logic [31:0] EX_data_a,
  input  logic [31:0] EX_data_b,
  input  logic [31:0] EX_data_c,
  input  logic [20:0] EX_aluc,
  input  logic        EX_sign,
  input  logic        EX_memread,
  input  logic        EX_memwrite,
  input  logic [31:0] EX_memaddr,
  input  logic [8:0]  EX_load_op,
  input  logic [5:0]  EX_store_op,
  input  logic        EX_memtoreg,
  input  logic        EX_regwrite,
  output logic        EX_stall,
  output logic [31:0] MEM_alu_result,
  output logic [31:0] MEM_store_data,
  output logic [4:0]  MEM_reg_dst,
  output logic        MEM_memread,
  output logic        MEM_memwrite,
  output logic        MEM_memtoreg,
  output logic        MEM_regwrite,
  output logic [31:0] MEM_memaddr,
  output logic [8:0]  MEM_load_op,
  output logic [5:0]  MEM_store_op
);
  logic [31:0] hi_r, lo_r, md_hi, md_lo, sra_v, res;
  logic is_md, md_busy, md_done, md_hold;
  assign is_md = EX_aluc[ALU_MULT] | EX_aluc[ALU_DIV];
  muldiv_unit #(.MUL_LAT(MUL_LAT), .DIV_ITERS(DIV_ITERS)) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (is_md & ~MEM_stall),
    .is_div (EX_aluc[ALU_DIV]),
    .sign   (EX_sign),
    .a      (EX_data_a),
    .b      (EX_data_b),
    .busy   (md_busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );
  // the mult/div instruction is held from its first EX cycle until DONE
  assign md_hold  = md_busy | (is_md & ~md_done);
  assign EX_stall = rst_n & (MEM_stall | md_hold);
  // kept separate so the arithmetic shift is not turned unsigned by the result mux
  assign sra_v = $signed(EX_data_b) >>> EX_data_a[4:0];
  always_comb
    res = |EX_aluc[20:17]   ? 32'd0 :
          EX_aluc[ALU_ADD]  ? EX_data_a + EX_data_b :
          EX_aluc[ALU_SUB]  ? EX_data_a - EX_data_b :
          EX_aluc[ALU_AND]  ? EX_data_a & EX_data_b :
          EX_aluc[ALU_OR]   ? EX_data_a | EX_data_b :
          EX_aluc[ALU_XOR]  ? EX_data_a ^ EX_data_b :
          EX_aluc[ALU_NOR]  ? ~(EX_data_a | EX_data_b) :
          EX_aluc[ALU_SLT]  ? {31'd0, EX_sign ? ($signed(EX_data_a) < $signed(EX_data_b)) : (EX_data_a < EX_data_b)} :
          EX_aluc[ALU_SLL]  ? EX_data_b << EX_data_a[4:0] :
          EX_aluc[ALU_SRL]  ? EX_data_b >> EX_data_a[4:0] :
          EX_aluc[ALU_SRA]  ? sra_v :
          EX_aluc[ALU_LUI]  ? {EX_data_b[15:0], 16'd0} :
          EX_aluc[ALU_MFHI] ? hi_r :
          EX_aluc[ALU_MFLO] ? lo_r : 32'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (md_done & ~MEM_stall) begin
      hi_r <= md_hi;
      lo_r <= md_lo;
    end else if (~EX_stall) begin
      if (EX_aluc[ALU_MTHI]) hi_r <= EX_data_a;
      if (EX_aluc[ALU_MTLO]) lo_r <= EX_data_a;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      MEM_alu_result <= '0;
      MEM_store_data <= '0;
      MEM_reg_dst    <= '0;
      MEM_memread    <= 1'b0;
      MEM_memwrite   <= 1'b0;
      MEM_memtoreg   <= 1'b0;
      MEM_regwrite   <= 1'b0;
      MEM_memaddr    <= '0;
      MEM_load_op    <= '0;
      MEM_store_op   <= '0;
    end else if (!MEM_stall) begin
      if (md_hold) begin
        MEM_memread  <= 1'b0;
        MEM_memwrite <= 1'b0;
        MEM_regwrite <= 1'b0;
      end else begin
        MEM_alu_result <= res;
        MEM_store_data <= EX_data_c;
        MEM_reg_dst    <= EX_reg_dst;
        MEM_memread    <= EX_memread & ~is_md;
        MEM_memwrite   <= EX_memwrite & ~is_md;
        MEM_memtoreg   <= EX_memtoreg;
        MEM_regwrite   <= EX_regwrite & ~is_md;
        MEM_memaddr    <= EX_memaddr;
        MEM_load_op    <= EX_load_op;
        MEM_store_op   <= EX_store_op;
      end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;
  localparam int ML = 4;
  logic clk = 0, rst_n = 0, MEM_stall = 0;
  logic [4:0] EX_reg_dst = 0;
  logic [31:0] EX_data_a = 0, EX_data_b = 0, EX_data_c = 0, EX_memaddr = 0;
  logic [20:0] EX_aluc = 0;
  logic EX_sign = 0, EX_memread = 0, EX_memwrite = 0, EX_memtoreg = 0, EX_regwrite = 0;
  logic [8:0] EX_load_op = 0;
  logic [5:0] EX_store_op = 0;
  logic EX_stall;
  logic [31:0] MEM_alu_result, MEM_store_data, MEM_memaddr;
  logic [4:0] MEM_reg_dst;
  logic MEM_memread, MEM_memwrite, MEM_memtoreg, MEM_regwrite;
  logic [8:0] MEM_load_op;
  logic [5:0] MEM_store_op;
  int errs = 0, checks = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  always #5 clk = ~clk;
  ex_stage #(.MUL_LAT(ML), .DIV_ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n), .MEM_stall(MEM_stall),
    .EX_reg_dst(EX_reg_dst), .EX_data_a(EX_data_a), .EX_data_b(EX_data_b), .EX_data_c(EX_data_c),
    .EX_aluc(EX_aluc), .EX_sign(EX_sign), .EX_memread(EX_memread), .EX_memwrite(EX_memwrite),
    .EX_memaddr(EX_memaddr), .EX_load_op(EX_load_op), .EX_store_op(EX_store_op),
    .EX_memtoreg(EX_memtoreg), .EX_regwrite(EX_regwrite), .EX_stall(EX_stall),
    .MEM_alu_result(MEM_alu_result), .MEM_store_data(MEM_store_data), .MEM_reg_dst(MEM_reg_dst),
    .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite), .MEM_memtoreg(MEM_memtoreg),
    .MEM_regwrite(MEM_regwrite), .MEM_memaddr(MEM_memaddr), .MEM_load_op(MEM_load_op),
    .MEM_store_op(MEM_store_op)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic [31:0] s;
    s = $signed(b) >>> a[4:0];
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ~(a | b);
      6: return {31'd0, sg ? ($signed(a) < $signed(b)) : (a < b)};
      7: return b << a[4:0];
      8: return b >> a[4:0];
      9: return s;
      10: return b << 16;
      13: return m_hi;
      14: return m_lo;
      default: return 32'd0;
    endcase
  endfunction
  task automatic md_ref(input logic dv, input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint xa, xb, p;
    xa = sg ? longint'($signed(a)) : longint'({32'd0, a});
    xb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    if (!dv) begin
      p = xa * xb;
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (b == 0) begin
      m_lo = (sg && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      m_hi = a;
    end else begin
      p = xa / xb;
      m_lo = p[31:0];
      p = xa % xb;
      m_hi = p[31:0];
    end
  endtask
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input logic sg,
                       input logic [31:0] c, input logic [31:0] addr, input logic rd, input logic wr, input logic rw);
    logic [31:0] er;
    logic [8:0] lop;
    logic [5:0] sop;
    logic [4:0] dst;
    logic md, m2r;
    int n, es;
    md = (op == 11) || (op == 12);
    er = ref_alu(op, a, b, sg);
    es = op == 11 ? ML + 1 : op == 12 ? 33 : 0;
    lop = 9'($urandom);
    sop = 6'($urandom);
    dst = 5'($urandom);
    m2r = 1'($urandom);
    EX_aluc = (op >= 0) ? 21'(1) << op : 21'd0;
    EX_data_a = a;
    EX_data_b = b;
    EX_sign = sg;
    EX_data_c = c;
    EX_memaddr = addr;
    EX_memread = rd;
    EX_memwrite = wr;
    EX_regwrite = rw;
    EX_memtoreg = m2r;
    EX_load_op = lop;
    EX_store_op = sop;
    EX_reg_dst = dst;
    n = 0;
    #1;
    while (EX_stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", 64'(n), 64'(es));
    @(negedge clk);
    if (md) begin
      md_ref(op == 12, a, b, sg);
      chk("md_ctl", 64'({MEM_memread, MEM_memwrite, MEM_regwrite}), 64'(0));
    end else begin
      if (op != 15 && op != 16) chk("result", 64'(MEM_alu_result), 64'(er));
      chk("store_data", 64'(MEM_store_data), 64'(c));
      chk("memaddr", 64'(MEM_memaddr), 64'(addr));
      chk("ctl", 64'({MEM_reg_dst, MEM_load_op, MEM_store_op, MEM_memread, MEM_memwrite, MEM_memtoreg, MEM_regwrite}),
          64'({dst, lop, sop, rd, wr, m2r, rw}));
      if (op == 15) m_hi = a;
      if (op == 16) m_lo = a;
    end
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    EX_aluc = 21'(1) << 12;
    repeat (2) @(negedge clk);
    chk("rst_result", 64'(MEM_alu_result), 64'(0));
    chk("rst_regwrite", 64'(MEM_regwrite), 64'(0));
    chk("rst_stall", 64'(EX_stall), 64'(0));
    EX_aluc = 0;
    rst_n = 1;
    @(negedge clk);
    issue(0, 32'h7FFF_FFFF, 32'd1, 0, 32'd0, 32'd0, 0, 0, 1);
    chk("add_wrap", 64'(MEM_alu_result), 64'h8000_0000);
    issue(9, 32'd4, 32'h8000_0000, 0, 32'd0, 32'd0, 0, 0, 1);
    chk("sra", 64'(MEM_alu_result), 64'hF800_0000);
    issue(6, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 32'd0, 0, 0, 1);
    chk("slt_s", 64'(MEM_alu_result), 64'd1);
    issue(6, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 32'd0, 0, 0, 1);
    chk("slt_u", 64'(MEM_alu_result), 64'd0);
    issue(11, -32'sd3, 32'd7, 1, 32'd0, 32'd0, 0, 0, 0);
    issue(13, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("mult_hi", 64'(MEM_alu_result), 64'hFFFF_FFFF);
    issue(14, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("mult_lo", 64'(MEM_alu_result), 64'hFFFF_FFEB);
    issue(12, -32'sd7, 32'd2, 1, 32'd0, 32'd0, 0, 0, 0);
    issue(14, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("div_lo", 64'(MEM_alu_result), 64'hFFFF_FFFD);
    issue(13, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("div_hi", 64'(MEM_alu_result), 64'hFFFF_FFFF);
    issue(12, 32'd5, 32'd0, 0, 32'd0, 32'd0, 0, 0, 0);
    issue(14, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("div0_lo", 64'(MEM_alu_result), 64'hFFFF_FFFF);
    issue(13, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("div0_hi", 64'(MEM_alu_result), 64'd5);
    issue(12, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'd0, 0, 0, 0);
    issue(14, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("divovf_lo", 64'(MEM_alu_result), 64'h8000_0000);
    issue(13, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("divovf_hi", 64'(MEM_alu_result), 64'd0);
    issue(16, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    issue(14, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("mtlo_mflo", 64'(MEM_alu_result), 64'h1234);
    issue(0, 32'hF0, 32'h10, 0, 32'd0, 32'h100, 1, 0, 1);
    MEM_stall = 1;
    EX_aluc = 21'(1) << 3;
    EX_memaddr = 32'h200;
    EX_memread = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ms_stall", 64'(EX_stall), 64'd1);
      @(negedge clk);
      chk("ms_addr", 64'(MEM_memaddr), 64'h100);
      chk("ms_rd", 64'(MEM_memread), 64'd1);
      chk("ms_res", 64'(MEM_alu_result), 64'h100);
    end
    MEM_stall = 0;
    issue(3, 32'hF0, 32'h0F, 0, 32'd0, 32'h200, 0, 0, 1);
    chk("ms_next", 64'(MEM_alu_result), 64'hFF);
    issue(-1, 0, 0, 0, 32'd0, 32'h300, 0, 0, 0);
    chk("ms_once", 64'(MEM_memaddr), 64'h300);
    issue(15, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    issue(16, 32'h55, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 32'd5, 32'd6, 0, 32'd0, 32'd0, 0, 0, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_regwrite", 64'(MEM_regwrite), 64'd0);
    chk("arst_result", 64'(MEM_alu_result), 64'd0);
    @(negedge clk);
    rst_n = 1;
    m_hi = 0;
    m_lo = 0;
    issue(13, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("arst_hi", 64'(MEM_alu_result), 64'd0);
    issue(16, 32'h77, 0, 0, 0, 0, 0, 0, 0);
    EX_aluc = 21'(1) << 12;
    EX_data_a = 32'd100;
    EX_data_b = 32'd3;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_stall", 64'(EX_stall), 64'd0);
    EX_aluc = 0;
    @(negedge clk);
    rst_n = 1;
    m_lo = 0;
    m_hi = 0;
    issue(14, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("abort_lo", 64'(MEM_alu_result), 64'd0);
    for (int i = 0; i < 150; i++)
      issue($urandom_range(0, 20), pick(), pick(), 1'($urandom), $urandom, $urandom,
            1'($urandom), 1'($urandom), 1'($urandom));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the MIPS32 five-stage pipeline.
- Consumes the registered EX_* bundle from the ID/EX register and computes the ALU result.
- Owns HI/LO and an iterative multiply/divide FSM, and drives EX_stall back to the ID/EX register.
- Registers results and memory controls into the MEM_* bundle for the memory stage.

Parameters:
- MUL_LAT, 4, cycles the multiplier spends in the BUSY state (1..15).
- DIV_ITERS, 32, restoring-division iterations; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- MEM_stall  in  1  downstream hold; freezes the MEM_* register
- EX_reg_dst  in  5  destination register number
- EX_data_a  in  32  operand A (rs); shift amount taken from [4:0]
- EX_data_b  in  32  operand B (rt or extended immediate)
- EX_data_c  in  32  store data, passed through unchanged
- EX_aluc  in  21  one-hot ALU operation; all zero means bubble
- EX_sign  in  1  signed compare/mult/div when 1
- EX_memread, EX_memwrite  in  1 each  memory controls
- EX_memaddr  in  32  memory address
- EX_load_op  in  9  load-op field
- EX_store_op  in  6  store-op field
- EX_memtoreg, EX_regwrite  in  1 each  writeback controls
- EX_stall  out  1  hold request to the ID/EX register
- MEM_alu_result  out  32  registered result
- MEM_store_data  out  32  registered EX_data_c
- MEM_reg_dst  out  5  registered destination register
- MEM_memread, MEM_memwrite, MEM_memtoreg, MEM_regwrite  out  1 each  registered controls
- MEM_memaddr  out  32  registered address
- MEM_load_op  out  9  registered load-op field
- MEM_store_op  out  6  registered store-op field

Behaviour:
- Reset is asynchronous active-low. While rst_n=0: every MEM_* output = 0, HI = LO = 0, FSM = IDLE, counter = 0, EX_stall = 0.
- aluc bit assignment:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt (signed per EX_sign), 7 sll, 8 srl, 9 sra (shift B by A[4:0])
  - 10 lui (B<<16), 11 mult, 12 div, 13 mfhi, 14 mflo, 15 mthi (HI<=A), 16 mtlo (LO<=A)
  - 17-20 reserved: result 0
- Arithmetic wraps modulo 2^32. No overflow trap.
- Single-cycle ops: the result is registered into MEM_* on the next clk edge. Latency is 1 cycle.
- FSM states are IDLE, BUSY, DONE.
- IDLE, EX_aluc[11] or [12] set, MEM_stall=0:
  - Latch operand magnitudes and signs. Go to BUSY; counter = MUL_LAT (mult) or 32 (div).
  - EX_stall=1 in this cycle.
- BUSY:
  - Multiplier or divider advances one step per cycle; counter decrements.
  - At counter==1, go to DONE.
  - EX_stall=1.
  - MEM_* takes a bubble: memread, memwrite and regwrite = 0; other fields are don't-care but must be deterministic (hold).
- DONE:
  - Write HI/LO. EX_stall = MEM_stall.
  - The instruction advances into MEM_* (as a bubble, since regwrite is 0) on the first edge with MEM_stall=0.
  - Then go to IDLE.
- Total occupancy: mult = MUL_LAT+2 cycles, div = 34 cycles.
- Mult result: {HI,LO} = 64-bit product, signed or unsigned per EX_sign.
- Div result: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Div by 0: LO = 0xFFFFFFFF and HI = dividend (unsigned). Signed div by 0 uses the same rule on magnitudes with sign fix applied.
- 0x80000000 / 0xFFFFFFFF signed: LO = 0x80000000, HI = 0.
- mthi/mtlo write HI/LO on the accepting edge. An mfhi/mflo in the next cycle sees the new value.
- MEM_stall=1:
  - MEM_* holds.
  - EX_stall=1 (the combinational term MEM_stall is ORed into EX_stall).
  - FSM in IDLE does not start. BUSY keeps counting. DONE waits.
- Reset mid-operation aborts the division/multiplication. HI/LO return to 0.
- EX_stall is combinational; no other output is combinational.

Decomposition:
- Package mips_ex_pkg holds:
  - aluc bit-index localparams (ALU_ADD..ALU_MTLO)
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - shared width constants
- Sub-module muldiv_unit contains the FSM, counter, shift-add/restoring datapath and sign correction.
  - Interface: start, is_div, sign, a, b in; busy, done, hi, lo out.
- ex_stage holds the combinational ALU, the HI/LO registers, the stall logic and the EX/MEM register.

Test Plan:
- Reset: rst_n low mid-cycle → MEM_regwrite=0 and MEM_alu_result=0 immediately, without waiting for clk.
- Single-cycle ops:
  - add 0x7FFFFFFF+1 → MEM_alu_result=0x80000000 one cycle later.
  - sra B=0x80000000, A[4:0]=4 → 0xF8000000.
  - slt signed: -1 < 1 → 1. Unsigned (EX_sign=0) → 0.
- Signed mult: A=-3, B=7, EX_sign=1, MUL_LAT=4 → EX_stall high exactly 5 cycles. Then mfhi → 0xFFFFFFFF, mflo → 0xFFFFFFEB.
- Signed div:
  - A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, after 33 stall cycles.
  - Divisor 0 with A=5 unsigned → LO=0xFFFFFFFF, HI=5.
- MEM_stall: assert for 3 cycles during a load (EX_memread=1, addr=0x100) → MEM_* frozen, EX_stall=1. Release → next instruction captured exactly once.
- Back-to-back: mtlo A=0x1234 then mflo → MEM_alu_result=0x1234 with no stall.
